// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg -- shared definitions for the alu_seq ALU.
//   ALU2_OPID_WIDTH : width of the op_id operation code
//   op_e            : opcode constants 0..15
//   state_e         : handshake FSM state encodings
package alu_seq_pkg;

  localparam int ALU2_OPID_WIDTH = 4;

  typedef enum logic [ALU2_OPID_WIDTH-1:0] {
    OP_AND  = 4'd0,
    OP_OR   = 4'd1,
    OP_XOR  = 4'd2,
    OP_TEST = 4'd3,
    OP_NEG  = 4'd4,
    OP_ADD  = 4'd5,
    OP_ADC  = 4'd6,
    OP_SUB  = 4'd7,
    OP_SBC  = 4'd8,
    OP_CMP  = 4'd9,
    OP_SHL  = 4'd10,
    OP_SHR  = 4'd11,
    OP_RLC  = 4'd12,
    OP_RRC  = 4'd13,
    OP_MUL  = 4'd14,
    OP_DIV  = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/alu_muldiv.sv
// alu_muldiv -- iterative unsigned multiply (shift-add) / divide (restoring).
// Built only when ALU_MULDIV_EN is defined.
//   clk, reset   : clock, asynchronous active-high reset
//   start        : load a/b and perform the first step (ignored while busy)
//   is_div       : 1 = divide, 0 = multiply
//   a, b         : operands
//   busy         : iteration in progress
//   done         : the final step happens at the coming clock edge
//   lo, hi       : MUL {hi,lo} = a*b ; DIV lo = quotient, hi = remainder
`ifdef ALU_MULDIV_EN
module alu_muldiv #(
  parameter int BITS = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            is_div,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [BITS-1:0] lo,
  output logic [BITS-1:0] hi
);

  localparam int CW = $clog2(BITS) + 1;

  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d, div_q, div_d;
  logic [BITS-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic            load, src_div;
  logic [BITS-1:0] src_hi, src_lo, src_b, hi_step, lo_step;
  logic [BITS:0]   sum, part, diff;

  always_comb begin
    load    = start && !busy_q;
    // On the load cycle the first step runs on the fresh operands, so a full
    // operation takes the load edge plus BITS-1 further edges.
    src_hi  = load ? '0 : hi_q;
    src_lo  = load ? a : lo_q;
    src_b   = load ? b : b_q;
    src_div = load ? is_div : div_q;

    sum  = {1'b0, src_hi} + (src_lo[0] ? {1'b0, src_b} : '0);
    part = {src_hi, src_lo[BITS-1]};
    diff = part - {1'b0, src_b};

    if (src_div) begin
      // diff[BITS] set means the trial subtraction borrowed: restore.
      hi_step = diff[BITS] ? part[BITS-1:0] : diff[BITS-1:0];
      lo_step = {src_lo[BITS-2:0], ~diff[BITS]};
    end else begin
      hi_step = sum[BITS:1];
      lo_step = {sum[0], src_lo[BITS-1:1]};
    end

    busy_d = busy_q;
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    b_d    = b_q;
    div_d  = div_q;
    if (load) begin
      busy_d = 1'b1;
      cnt_d  = CW'(BITS - 1);   // steps still to do after this one
      hi_d   = hi_step;
      lo_d   = lo_step;
      b_d    = b;
      div_d  = is_div;
    end else if (busy_q) begin
      hi_d  = hi_step;
      lo_d  = lo_step;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      b_q    <= '0;
      div_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      b_q    <= b_d;
      div_q  <= div_d;
    end
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == CW'(1));
  assign lo   = lo_q;
  assign hi   = hi_q;

endmodule
`endif

// File: rtl/alu_seq.sv
// alu_seq -- sequential integer ALU with start/ready/valid handshake.
// Optional MUL/DIV via alu_muldiv when ALU_MULDIV_EN is defined; otherwise
// those opcodes act as NOP and ready never drops.
//   clk, reset : clock, asynchronous active-high reset
//   start      : request, accepted only while ready=1
//   op_id      : operation code (alu_seq_pkg::op_e)
//   op1, op2   : operands
//   ready      : idle and able to accept start
//   valid      : one-cycle pulse when out/out_hi/flags were updated
//   out,out_hi : result / MUL high half or DIV remainder (0 otherwise)
//   z,n,c,v    : zero, negative, carry/borrow, overflow/div-by-zero flags
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter  int BITS = 16,
  localparam int SHW  = $clog2(BITS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [ALU2_OPID_WIDTH-1:0] op_id,
  input  logic [BITS-1:0]            op1,
  input  logic [BITS-1:0]            op2,
  output logic                       ready,
  output logic                       valid,
  output logic [BITS-1:0]            out,
  output logic [BITS-1:0]            out_hi,
  output logic                       z,
  output logic                       n,
  output logic                       c,
  output logic                       v
);

  localparam int              M        = BITS - 1;
  localparam logic [BITS-1:0] MIN_NEG  = {1'b1, {(BITS-1){1'b0}}};
  localparam logic [BITS-1:0] BITS_VAL = BITS'(BITS);

  state_e          state_q, state_d;
  logic [BITS-1:0] out_q, out_d, out_hi_q, out_hi_d;
  logic            z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d, valid_q, valid_d;

  logic [BITS:0]   ext;
  logic [BITS-1:0] res;
  logic            res_c, res_v, upd, keep_out;
  logic [SHW-1:0]  sh_amt;
  logic            sh_big, sh_eq;

  assign sh_amt = op2[SHW-1:0];
  assign sh_big = |op2[BITS-1:SHW];
  assign sh_eq  = (op2 == BITS_VAL);

`ifdef ALU_MULDIV_EN
  logic            md_start, md_busy, md_done, op_div_q, op_div_d;
  logic [BITS-1:0] md_lo, md_hi;

  alu_muldiv #(.BITS(BITS)) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start),
    .is_div (op_div_d),
    .a      (op1),
    .b      (op2),
    .busy   (md_busy),
    .done   (md_done),
    .lo     (md_lo),
    .hi     (md_hi)
  );
`endif

  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    out_hi_d = out_hi_q;
    z_d      = z_q;
    n_d      = n_q;
    c_d      = c_q;
    v_d      = v_q;
    valid_d  = 1'b0;
    ext      = '0;
    res      = out_q;
    res_c    = c_q;
    res_v    = 1'b0;
    upd      = 1'b0;
    keep_out = 1'b0;
`ifdef ALU_MULDIV_EN
    md_start = 1'b0;
    op_div_d = op_div_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          valid_d = 1'b1;
          upd     = 1'b1;
          case (op_id)
            OP_AND:  res = op1 & op2;
            OP_OR:   res = op1 | op2;
            OP_XOR:  res = op1 ^ op2;
            OP_TEST: begin
              res      = op1 & op2;
              keep_out = 1'b1;
            end
            OP_NEG: begin
              res   = '0 - op1;
              res_c = |op1;
              res_v = (op1 == MIN_NEG);
            end
            OP_ADD, OP_ADC: begin
              ext   = {1'b0, op1} + {1'b0, op2}
                    + {{BITS{1'b0}}, (op_id == OP_ADC) & c_q};
              res   = ext[BITS-1:0];
              res_c = ext[BITS];
              res_v = (op1[M] == op2[M]) && (res[M] != op1[M]);
            end
            OP_SUB, OP_SBC, OP_CMP: begin
              // ext[BITS] is the borrow out of the subtraction.
              ext      = {1'b0, op1} - {1'b0, op2}
                       - {{BITS{1'b0}}, (op_id == OP_SBC) & c_q};
              res      = ext[BITS-1:0];
              res_c    = ext[BITS];
              res_v    = (op1[M] != op2[M]) && (res[M] != op1[M]);
              keep_out = (op_id == OP_CMP);
            end
            OP_SHL: begin
              // One spare bit above the word catches the last bit shifted out.
              ext   = {1'b0, op1} << sh_amt;
              res   = ext[BITS-1:0];
              res_c = ext[BITS];
              if (sh_big) begin
                res   = '0;
                res_c = sh_eq & op1[0];
              end
            end
            OP_SHR: begin
              ext   = {op1, 1'b0} >> sh_amt;
              res   = ext[BITS:1];
              res_c = ext[0];
              if (sh_big) begin
                res   = '0;
                res_c = sh_eq & op1[M];
              end
            end
            OP_RLC: begin
              res   = {op1[BITS-2:0], c_q};
              res_c = op1[M];
            end
            OP_RRC: begin
              res   = {c_q, op1[BITS-1:1]};
              res_c = op1[0];
            end
`ifdef ALU_MULDIV_EN
            OP_MUL: begin
              upd      = 1'b0;
              valid_d  = 1'b0;
              md_start = 1'b1;
              op_div_d = 1'b0;
              state_d  = ST_MUL;
            end
            OP_DIV: begin
              upd = 1'b0;
              if (op2 == '0) begin
                // Divide by zero completes immediately.
                out_d    = '1;
                out_hi_d = op1;
                z_d      = 1'b0;
                n_d      = 1'b1;
                v_d      = 1'b1;
              end else begin
                valid_d  = 1'b0;
                md_start = 1'b1;
                op_div_d = 1'b1;
                state_d  = ST_DIV;
              end
            end
`endif
            default: upd = 1'b0;   // NOP: valid pulses, everything holds
          endcase
          if (upd) begin
            if (!keep_out) out_d = res;
            out_hi_d = '0;
            z_d      = (res == '0);
            n_d      = res[M];
            c_d      = res_c;
            v_d      = res_v;
          end
        end
      end
`ifdef ALU_MULDIV_EN
      ST_MUL, ST_DIV: begin
        if (md_done)       state_d = ST_DONE;
        else if (!md_busy) state_d = ST_IDLE;  // datapath lost its operation
      end
      ST_DONE: begin
        valid_d  = 1'b1;
        state_d  = ST_IDLE;
        out_d    = md_lo;
        out_hi_d = md_hi;
        z_d      = (md_lo == '0);
        n_d      = md_lo[M];
        v_d      = 1'b0;
        if (!op_div_q) c_d = |md_hi;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      out_q    <= '0;
      out_hi_q <= '0;
      z_q      <= 1'b1;
      n_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      valid_q  <= 1'b0;
`ifdef ALU_MULDIV_EN
      op_div_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      out_hi_q <= out_hi_d;
      z_q      <= z_d;
      n_q      <= n_d;
      c_q      <= c_d;
      v_q      <= v_d;
      valid_q  <= valid_d;
`ifdef ALU_MULDIV_EN
      op_div_q <= op_div_d;
`endif
    end
  end

  assign ready  = (state_q == ST_IDLE);
  assign valid  = valid_q;
  assign out    = out_q;
  assign out_hi = out_hi_q;
  assign z      = z_q;
  assign n      = n_q;
  assign c      = c_q;
  assign v      = v_q;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int BITS = 16;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [3:0]  op_id;
  logic [15:0] op1, op2;
  logic        ready, valid, z, n, c, v;
  logic [15:0] out, out_hi;

  int total = 0;
  int bad   = 0;
  int vc, lc, cnt;

  alu_seq #(.BITS(BITS)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op_id  (op_id),
    .op1    (op1),
    .op2    (op2),
    .ready  (ready),
    .valid  (valid),
    .out    (out),
    .out_hi (out_hi),
    .z      (z),
    .n      (n),
    .c      (c),
    .v      (v)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge (one active edge later).
  task automatic do_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    start = 1'b1;
    op_id = op;
    op1   = a;
    op2   = b;
    @(negedge clk);
    start = 1'b0;
    $display("txn op=%0d a=%04h b=%04h : valid=%0b ready=%0b out=%04h hi=%04h zncv=%04b",
             op, a, b, valid, ready, out, out_hi, {z, n, c, v});
  endtask

  // Waits (bounded) for valid after a multi-cycle accept; k counts cycles
  // since the accept edge. Optionally pulses a stray start while busy.
  task automatic run_busy(output int vcyc, output int lowc, input bit stray);
    vcyc = 0;
    lowc = 0;
    for (int k = 1; k <= 40; k++) begin
      if (valid) begin
        vcyc = k;
        break;
      end
      if (!ready) lowc++;
      if (stray && k == 3) begin
        start = 1'b1;
        op_id = OP_ADD;
        op1   = 16'h0001;
        op2   = 16'h0001;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op_id = '0;
    op1   = '0;
    op2   = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_valid", valid, 0);
    check("rst_out", out, 16'h0000);
    check("rst_out_hi", out_hi, 16'h0000);
    check("rst_zncv", {z, n, c, v}, 4'b1000);
    reset = 1'b0;
    @(negedge clk);

    // Asynchronous reset in the middle of a cycle
    do_op(OP_ADD, 16'hFFFF, 16'h0002);
    check("pre_rst_out", out, 16'h0001);
    check("pre_rst_zncv", {z, n, c, v}, 4'b0010);
    #2 reset = 1'b1;
    #1;
    check("async_rst_out", out, 16'h0000);
    check("async_rst_zncv", {z, n, c, v}, 4'b1000);
    check("async_rst_ready", ready, 1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    do_op(OP_ADD, 16'hFFFF, 16'h0001);
    check("add_valid", valid, 1);
    check("add_out", out, 16'h0000);
    check("add_out_hi", out_hi, 16'h0000);
    check("add_zncv", {z, n, c, v}, 4'b1010);
    @(negedge clk);
    check("add_valid_drop", valid, 0);
    do_op(OP_ADC, 16'h0000, 16'h0000);
    check("adc_out", out, 16'h0001);
    check("adc_zncv", {z, n, c, v}, 4'b0000);
    do_op(OP_ADD, 16'h7FFF, 16'h0001);
    check("add_ovf_out", out, 16'h8000);
    check("add_ovf_zncv", {z, n, c, v}, 4'b0101);
    do_op(OP_CMP, 16'h0005, 16'h0005);
    check("cmp_valid", valid, 1);
    check("cmp_out_kept", out, 16'h8000);
    check("cmp_zncv", {z, n, c, v}, 4'b1000);
    do_op(OP_SUB, 16'h0003, 16'h0005);
    check("sub_out", out, 16'hFFFE);
    check("sub_zncv", {z, n, c, v}, 4'b0110);
    do_op(OP_SBC, 16'h0005, 16'h0003);
    check("sbc_out", out, 16'h0001);
    check("sbc_zncv", {z, n, c, v}, 4'b0000);
    do_op(OP_NEG, 16'h8000, 16'h0000);
    check("neg_min_out", out, 16'h8000);
    check("neg_min_zncv", {z, n, c, v}, 4'b0111);
    do_op(OP_NEG, 16'h0000, 16'h0000);
    check("neg_zero_zncv", {z, n, c, v}, 4'b1000);

    do_op(OP_ADD, 16'hFFFF, 16'h0001);
    do_op(OP_AND, 16'hF0F0, 16'h0FF0);
    check("and_out", out, 16'h00F0);
    check("and_zncv", {z, n, c, v}, 4'b0010);
    do_op(OP_OR, 16'h00F0, 16'h0F00);
    check("or_out", out, 16'h0FF0);
    do_op(OP_XOR, 16'hFFFF, 16'h00FF);
    check("xor_out", out, 16'hFF00);
    check("xor_zncv", {z, n, c, v}, 4'b0110);
    do_op(OP_TEST, 16'h0F0F, 16'hF0F0);
    check("test_out_kept", out, 16'hFF00);
    check("test_zncv", {z, n, c, v}, 4'b1010);

    do_op(OP_SHL, 16'h8001, 16'd1);
    check("shl1_out", out, 16'h0002);
    check("shl1_zncv", {z, n, c, v}, 4'b0010);
    do_op(OP_SHL, 16'h8001, 16'd0);
    check("shl0_out", out, 16'h8001);
    check("shl0_zncv", {z, n, c, v}, 4'b0100);
    do_op(OP_SHR, 16'h8001, 16'd16);
    check("shr16_out", out, 16'h0000);
    check("shr16_zncv", {z, n, c, v}, 4'b1010);
    do_op(OP_SHL, 16'h0003, 16'd17);
    check("shl17_zncv", {z, n, c, v}, 4'b1000);
    do_op(OP_SHR, 16'h0003, 16'd1);
    check("shr1_out", out, 16'h0001);
    check("shr1_c", c, 1);
    do_op(OP_RRC, 16'h0001, 16'h0000);
    check("rrc_out", out, 16'h8000);
    check("rrc_zncv", {z, n, c, v}, 4'b0110);
    do_op(OP_RLC, 16'h8000, 16'h0000);
    check("rlc_out", out, 16'h0001);
    check("rlc_c", c, 1);
    do_op(OP_RLC, 16'h0000, 16'h0000);
    check("rlc0_out", out, 16'h0001);
    check("rlc0_zncv", {z, n, c, v}, 4'b0000);

`ifdef ALU_MULDIV_EN
    do_op(OP_MUL, 16'h1234, 16'h0100);
    check("mul_busy_ready", ready, 0);
    run_busy(vc, lc, 1'b1);
    check("mul_latency", vc, 17);
    check("mul_ready_low", lc, 16);
    check("mul_out", out, 16'h3400);
    check("mul_out_hi", out_hi, 16'h0012);
    check("mul_zncv", {z, n, c, v}, 4'b0010);
    @(negedge clk);
    check("mul_valid_drop", valid, 0);
    check("mul_stray_ignored", out, 16'h3400);

    do_op(OP_DIV, 16'd100, 16'd7);
    run_busy(vc, lc, 1'b0);
    check("div_latency", vc, 17);
    check("div_out", out, 16'd14);
    check("div_out_hi", out_hi, 16'd2);
    check("div_zncv", {z, n, c, v}, 4'b0010);
    do_op(OP_DIV, 16'd9, 16'd0);
    check("div0_valid", valid, 1);
    check("div0_out", out, 16'hFFFF);
    check("div0_out_hi", out_hi, 16'h0009);
    check("div0_zncv", {z, n, c, v}, 4'b0111);

    do_op(OP_MUL, 16'h1234, 16'h0100);
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mulrst_ready", ready, 1);
    check("mulrst_valid", valid, 0);
    check("mulrst_out", out, 16'h0000);
    check("mulrst_out_hi", out_hi, 16'h0000);
    check("mulrst_zncv", {z, n, c, v}, 4'b1000);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (valid) cnt++;
    end
    check("mulrst_no_valid", cnt, 0);
    do_op(OP_MUL, 16'h00FF, 16'h00FF);
    run_busy(vc, lc, 1'b0);
    check("mul2_latency", vc, 17);
    check("mul2_out", out, 16'hFE01);
    check("mul2_out_hi", out_hi, 16'h0000);
    check("mul2_zncv", {z, n, c, v}, 4'b0100);
`else
    do_op(OP_MUL, 16'h1234, 16'h0100);
    check("nop_mul_valid", valid, 1);
    check("nop_mul_ready", ready, 1);
    check("nop_mul_out", out, 16'h0001);
    check("nop_mul_zncv", {z, n, c, v}, 4'b0000);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!ready) cnt++;
    end
    check("nop_ready_never_low", cnt, 0);
    do_op(OP_DIV, 16'd9, 16'd0);
    check("nop_div_valid", valid, 1);
    check("nop_div_out", out, 16'h0001);
    check("nop_div_out_hi", out_hi, 16'h0000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
